// File: rtl/hazard_sequencer_pkg.sv
// Shared types for the hazard sequencer: sequencer states, operand-select codes
// and the register-match rule used by both the stall and the forwarding logic.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // $0 is hardwired to zero, so a write to it can never create a dependency.
    function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_sequencer_fwd_unit.sv
// Operand-select logic for one ALU operand; the youngest producer (EX/MEM) wins
// over the older MEM/WB result.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_regwrite,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_regwrite,
    output logic [1:0] o_fwd
);

    always_comb begin
        o_fwd = FWD_RF;
        if (i_mem_regwrite && regMatch(i_mem_rd, i_rs)) begin
            o_fwd = FWD_MEM;
        end else if (i_wb_regwrite && regMatch(i_wb_rd, i_rs)) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, data-memory freeze
// with timeout, and operand forwarding when HAZARD_FORWARD_EN is defined.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_regwrite,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_mem_rd,
    input  logic             i_mem_regwrite,
    input  logic [4:0]       i_wb_rd,
    input  logic             i_wb_regwrite,
    input  logic             i_mem_branch_taken,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    output logic             o_pc_we,
    output logic             o_ifid_we,
    output logic             o_idex_we,
    output logic             o_exmem_we,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic             o_memwb_flush,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_memErr;
    logic [CNT_W-1:0]  r_stallCnt;
    logic [1:0]        w_fwdA;
    logic [1:0]        w_fwdB;
    logic              w_loadUse;
    logic              w_dataHaz;
    logic              w_freeze;
    logic              w_resolve;

    fwd_unit u_fwdA (
        .i_rs           (i_id_rs),
        .i_mem_rd       (i_mem_rd),
        .i_mem_regwrite (i_mem_regwrite),
        .i_wb_rd        (i_wb_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .o_fwd          (w_fwdA)
    );

    fwd_unit u_fwdB (
        .i_rs           (i_id_rt),
        .i_mem_rd       (i_mem_rd),
        .i_mem_regwrite (i_mem_regwrite),
        .i_wb_rd        (i_wb_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .o_fwd          (w_fwdB)
    );

    assign w_loadUse = i_ex_memread && i_ex_regwrite &&
                       (regMatch(i_ex_rd, i_id_rs) || regMatch(i_ex_rd, i_id_rt));

    // Without forwarding, any match the forwarding unit would have resolved
    // must instead hold the consumer in ID until the producer retires.
`ifdef HAZARD_FORWARD_EN
    assign w_dataHaz = 1'b0;
    assign o_fwd_a   = rst ? FWD_RF : w_fwdA;
    assign o_fwd_b   = rst ? FWD_RF : w_fwdB;
`else
    assign w_dataHaz = (w_fwdA != FWD_RF) || (w_fwdB != FWD_RF);
    assign o_fwd_a   = FWD_RF;
    assign o_fwd_b   = FWD_RF;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_waitCnt  <= '0;
            r_memErr   <= 1'b0;
            r_stallCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state != ST_MEM_WAIT) begin
                r_waitCnt <= '0;
            end else if (!i_dmem_ack) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
            if (w_nextState == ST_ERR) begin
                r_memErr <= 1'b1;
            end
            if (!o_pc_we && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
        end
    end

    // w_resolve marks cycles where branch/load-use may act; hazards seen while
    // frozen are simply not acted on until the acknowledging cycle.
    always_comb begin
        w_nextState = r_state;
        w_freeze    = 1'b0;
        w_resolve   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_dmem_req && !i_dmem_ack) begin
                    w_freeze    = 1'b1;
                    w_nextState = ST_MEM_WAIT;
                end else begin
                    w_resolve = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (i_dmem_ack) begin
                    w_resolve   = 1'b1;
                    w_nextState = ST_RUN;
                end else begin
                    w_freeze = 1'b1;
                    if (r_waitCnt == WAIT_LAST) begin
                        w_nextState = ST_ERR;
                    end
                end
            end
            ST_ERR:  w_freeze = 1'b1;
            default: w_nextState = ST_RUN;
        endcase
    end

    always_comb begin
        o_pc_we       = 1'b1;
        o_ifid_we     = 1'b1;
        o_idex_we     = 1'b1;
        o_exmem_we    = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;
        o_memwb_flush = 1'b0;
        if (!rst) begin
            if (w_freeze) begin
                o_pc_we       = 1'b0;
                o_ifid_we     = 1'b0;
                o_idex_we     = 1'b0;
                o_exmem_we    = 1'b0;
                o_memwb_flush = 1'b1;
            end else if (w_resolve) begin
                if (i_mem_branch_taken) begin
                    o_ifid_flush  = 1'b1;
                    o_idex_flush  = 1'b1;
                    o_exmem_flush = 1'b1;
                end else if (w_loadUse || w_dataHaz) begin
                    o_pc_we      = 1'b0;
                    o_ifid_we    = 1'b0;
                    o_idex_flush = 1'b1;
                end
            end
        end
    end

    assign o_mem_err   = r_memErr;
    assign o_stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: vector table, directed multi-cycle
// sequences and randomized traffic against a flag-based reference model.
module tb_hazard_sequencer;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, exmem_flush, memwb_flush}
    localparam logic [7:0] C_NORM   = 8'b1111_0000;
    localparam logic [7:0] C_STALL  = 8'b0011_0100;
    localparam logic [7:0] C_BRANCH = 8'b1111_1110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0001;

    typedef struct {
        logic [4:0] rs, rt, exRd;
        logic       exRw, exMr;
        logic [4:0] memRd;
        logic       memRw;
        logic [4:0] wbRd;
        logic       wbRw, br, req, ack;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] ctrl;
        logic [1:0] fa, fb;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       idRs, idRt, exRd, memRd, wbRd;
    logic             exRw, exMr, memRw, wbRw, brTaken, dmemReq, dmemAck;
    logic             pcWe, ifidWe, idexWe, exmemWe;
    logic             ifidFlush, idexFlush, exmemFlush, memwbFlush;
    logic [1:0]       fwdA, fwdB;
    logic             memErr;
    logic [CNT_W-1:0] stallCnt;
    logic [7:0]       dutCtrl;
    logic [7:0]       seenCtrl;

    int checks = 0;
    int passes = 0;

    // Reference model state: simple flags and integer counters.
    bit mWaiting, mErrored;
    int mWaitCycles, mStalls;

    assign dutCtrl = {pcWe, ifidWe, idexWe, exmemWe, ifidFlush, idexFlush, exmemFlush, memwbFlush};

    always #5 clk = ~clk;

    hazard_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_id_rs            (idRs),
        .i_id_rt            (idRt),
        .i_ex_rd            (exRd),
        .i_ex_regwrite      (exRw),
        .i_ex_memread       (exMr),
        .i_mem_rd           (memRd),
        .i_mem_regwrite     (memRw),
        .i_wb_rd            (wbRd),
        .i_wb_regwrite      (wbRw),
        .i_mem_branch_taken (brTaken),
        .i_dmem_req         (dmemReq),
        .i_dmem_ack         (dmemAck),
        .o_pc_we            (pcWe),
        .o_ifid_we          (ifidWe),
        .o_idex_we          (idexWe),
        .o_exmem_we         (exmemWe),
        .o_ifid_flush       (ifidFlush),
        .o_idex_flush       (idexFlush),
        .o_exmem_flush      (exmemFlush),
        .o_memwb_flush      (memwbFlush),
        .o_fwd_a            (fwdA),
        .o_fwd_b            (fwdB),
        .o_mem_err          (memErr),
        .o_stall_cnt        (stallCnt)
    );

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] eRd,
                                 input logic eRw, input logic eMr, input logic [4:0] mRd,
                                 input logic mRw, input logic [4:0] wRd, input logic wRw,
                                 input logic br, input logic req, input logic ack);
        stim_t s;
        s.rs = rs; s.rt = rt; s.exRd = eRd; s.exRw = eRw; s.exMr = eMr;
        s.memRd = mRd; s.memRw = mRw; s.wbRd = wRd; s.wbRw = wRw;
        s.br = br; s.req = req; s.ack = ack;
        return s;
    endfunction

    function automatic vec_t mkVec(input stim_t s, input logic [7:0] c, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.s = s; v.ctrl = c; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    function automatic bit producerHit(input logic [4:0] r);
        return (r != 0) && ((memRw && memRd == r) || (wbRw && wbRd == r));
    endfunction

    function automatic logic [1:0] refFwd(input logic [4:0] r);
        if (!FWD_ON || rst || r == 0) return 2'b00;
        if (memRw && memRd == r) return 2'b10;
        if (wbRw && wbRd == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] refCtrl();
        bit frozen, loadUse, dataHaz;
        if (rst) return C_NORM;
        frozen = mErrored || (mWaiting && !dmemAck) || (!mWaiting && dmemReq && !dmemAck);
        if (frozen) return C_FREEZE;
        if (brTaken) return C_BRANCH;
        loadUse = exMr && exRw && exRd != 0 && (exRd == idRs || exRd == idRt);
        dataHaz = !FWD_ON && (producerHit(idRs) || producerHit(idRt));
        if (loadUse || dataHaz) return C_STALL;
        return C_NORM;
    endfunction

    task automatic modelReset();
        mWaiting = 0; mErrored = 0; mWaitCycles = 0; mStalls = 0;
    endtask

    // Called just before the active edge with the cycle's inputs still applied.
    task automatic modelAdvance();
        logic [7:0] c;
        if (rst) begin
            modelReset();
            return;
        end
        c = refCtrl();
        if (!c[7] && mStalls < CNT_MAX) mStalls++;
        if (mErrored) begin
        end else if (mWaiting) begin
            if (dmemAck) begin
                mWaiting = 0;
            end else begin
                mWaitCycles++;
                if (mWaitCycles == MEM_TIMEOUT) begin
                    mErrored = 1;
                    mWaiting = 0;
                end
            end
        end else if (dmemReq && !dmemAck) begin
            mWaiting    = 1;
            mWaitCycles = 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    endtask

    task automatic checkModel(input string tag);
        if (rst) modelReset();
        seenCtrl = dutCtrl;
        checkOutput({tag, "_ctrl"}, dutCtrl, refCtrl());
        checkOutput({tag, "_fwd_a"}, fwdA, refFwd(idRs));
        checkOutput({tag, "_fwd_b"}, fwdB, refFwd(idRt));
        checkOutput({tag, "_mem_err"}, memErr, mErrored);
        checkOutput({tag, "_stall_cnt"}, stallCnt, mStalls);
    endtask

    task automatic setInputs(input stim_t s);
        idRs = s.rs; idRt = s.rt; exRd = s.exRd; exRw = s.exRw; exMr = s.exMr;
        memRd = s.memRd; memRw = s.memRw; wbRd = s.wbRd; wbRw = s.wbRw;
        brTaken = s.br; dmemReq = s.req; dmemAck = s.ack;
    endtask

    // Inputs change just after the active edge; outputs are sampled on the falling edge.
    task automatic applyStimulus(input stim_t s, input string tag);
        setInputs(s);
        @(negedge clk);
        checkModel(tag);
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0,0), "reset");
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[14];
        int   frozenCycles;
        stim_t s;

        modelReset();
        setInputs(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        doReset();

        vecs[0]  = mkVec(mk(0,0,0,0,0,0,0,0,0,0,0,0), C_NORM, 2'd0, 2'd0);
        vecs[1]  = mkVec(mk(2,4,2,1,1,0,0,0,0,0,0,0), C_STALL, 2'd0, 2'd0);
        vecs[2]  = mkVec(mk(4,7,7,1,1,0,0,0,0,0,0,0), C_STALL, 2'd0, 2'd0);
        vecs[3]  = mkVec(mk(0,0,0,1,1,0,0,0,0,0,0,0), C_NORM, 2'd0, 2'd0);
        vecs[4]  = mkVec(mk(2,3,2,0,1,0,0,0,0,0,0,0), C_NORM, 2'd0, 2'd0);
        vecs[5]  = mkVec(mk(2,4,2,1,1,0,0,0,0,1,0,0), C_BRANCH, 2'd0, 2'd0);
        vecs[6]  = mkVec(mk(2,2,0,0,0,2,1,0,0,0,0,0), FWD_ON ? C_NORM : C_STALL,
                         FWD_ON ? 2'd2 : 2'd0, FWD_ON ? 2'd2 : 2'd0);
        vecs[7]  = mkVec(mk(1,4,0,0,0,0,0,4,1,0,0,0), FWD_ON ? C_NORM : C_STALL,
                         2'd0, FWD_ON ? 2'd1 : 2'd0);
        vecs[8]  = mkVec(mk(5,6,0,0,0,5,1,5,1,0,0,0), FWD_ON ? C_NORM : C_STALL,
                         FWD_ON ? 2'd2 : 2'd0, 2'd0);
        vecs[9]  = mkVec(mk(0,0,0,0,0,0,1,0,1,0,0,0), C_NORM, 2'd0, 2'd0);
        vecs[10] = mkVec(mk(3,0,3,1,1,0,0,0,0,0,1,1), C_STALL, 2'd0, 2'd0);
        vecs[11] = mkVec(mk(3,9,0,0,0,3,0,3,1,0,0,0), FWD_ON ? C_NORM : C_STALL,
                         FWD_ON ? 2'd1 : 2'd0, 2'd0);
        vecs[12] = mkVec(mk(0,0,0,0,0,0,0,0,0,1,0,1), C_BRANCH, 2'd0, 2'd0);
        vecs[13] = mkVec(mk(2,0,2,1,0,0,0,0,0,0,0,0), C_NORM, 2'd0, 2'd0);

        foreach (vecs[i]) begin
            setInputs(vecs[i].s);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ctrl", i), dutCtrl, vecs[i].ctrl);
            checkOutput($sformatf("vec%0d_fwd_a", i), fwdA, vecs[i].fa);
            checkOutput($sformatf("vec%0d_fwd_b", i), fwdB, vecs[i].fb);
            modelAdvance();
            @(posedge clk);
            #1;
        end

        // lw $2 followed by add $3,$2,$4 as the load travels EX -> MEM -> WB.
        doReset();
        applyStimulus(mk(2,4,2,1,1,0,0,0,0,0,0,0), "lwuse_ex");
        applyStimulus(mk(2,4,0,0,0,2,1,0,0,0,0,0), "lwuse_mem");
        applyStimulus(mk(2,4,0,0,0,0,0,2,1,0,0,0), "lwuse_wb");
        applyStimulus(mk(2,4,0,0,0,0,0,0,0,0,0,0), "lwuse_done");
        checkOutput("lwuse_stall_total", stallCnt, FWD_ON ? 1 : 3);

        // add $2 followed by sub $5,$2,$2.
        doReset();
        applyStimulus(mk(2,2,2,1,0,0,0,0,0,0,0,0), "alu_ex");
        applyStimulus(mk(2,2,0,0,0,2,1,0,0,0,0,0), "alu_mem");
        applyStimulus(mk(2,2,0,0,0,0,0,2,1,0,0,0), "alu_wb");
        checkOutput("alu_stall_total", stallCnt, FWD_ON ? 0 : 2);

        // Three-cycle memory wait with a branch pending the whole time.
        doReset();
        frozenCycles = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(0,0,0,0,0,0,0,0,0,1,1,0), "memwait");
            if (seenCtrl == C_FREEZE) frozenCycles++;
        end
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,1,1,1), "memwait_ack");
        checkOutput("memwait_ack_branch", seenCtrl, C_BRANCH);
        checkOutput("memwait_frozen_cycles", frozenCycles, 3);
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0,0), "memwait_after");
        checkOutput("memwait_back_to_run", seenCtrl, C_NORM);
        checkOutput("memwait_stall_total", stallCnt, 3);

        // Memory never acknowledges: error after the timeout, then reset mid-cycle.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,1,0), "timeout");
            checkOutput($sformatf("timeout_err_%0d", i), memErr, (i == 15));
        end
        applyStimulus(mk(2,0,2,1,1,0,0,0,0,1,1,1), "err_hold");
        checkOutput("err_still_frozen", seenCtrl, C_FREEZE);
        setInputs(mk(2,2,2,1,1,2,1,2,1,1,1,0));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_ctrl", dutCtrl, C_NORM);
        checkOutput("rst_async_fwd", {fwdA, fwdB}, 4'b0000);
        checkOutput("rst_async_mem_err", memErr, 0);
        checkOutput("rst_async_stall_cnt", stallCnt, 0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0,0), "post_rst");
        checkOutput("post_rst_run", seenCtrl, C_NORM);

        // Counter saturates instead of wrapping.
        doReset();
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            applyStimulus(mk(2,4,2,1,1,0,0,0,0,0,0,0), "sat");
        end
        checkOutput("stall_cnt_saturated", stallCnt, CNT_MAX);

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 500; i++) begin
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.exRd  = 5'($urandom_range(0, 3));
            s.exRw  = 1'($urandom_range(0, 1));
            s.exMr  = 1'($urandom_range(0, 1));
            s.memRd = 5'($urandom_range(0, 3));
            s.memRw = 1'($urandom_range(0, 1));
            s.wbRd  = 5'($urandom_range(0, 3));
            s.wbRw  = 1'($urandom_range(0, 1));
            s.br    = ($urandom_range(0, 7) == 0);
            s.req   = ($urandom_range(0, 3) == 0);
            s.ack   = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            applyStimulus(s, "rand");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum data-memory wait cycles before an error is flagged.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  in  1  pipeline clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 ex_rd  in  5  destination register selected in EX (post RegDst mux).
REQ-007 ex_regwrite, ex_memread  in  1 each  EX-stage WB[1] and M MemRead.
REQ-008 mem_rd  in  5  EX/MEM destination register; mem_regwrite  in  1  EX/MEM WB[1].
REQ-009 wb_rd  in  5  MEM/WB destination register; wb_regwrite  in  1  MEM/WB WB[1].
REQ-010 mem_branch_taken  in  1  Branch AND zero, in MEM.
REQ-011 dmem_req  in  1  MEM-stage MemRead|MemWrite; dmem_ack  in  1  data-memory completion.
REQ-012 pc_we, ifid_we, idex_we, exmem_we  out  1 each  register load enables.
REQ-013 ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  insert bubble (zero control bits).
REQ-014 fwd_a, fwd_b  out  2 each  ALU operand select: 00 register file, 01 MEM/WB, 10 EX/MEM.
REQ-015 mem_err  out  1  sticky timeout flag; stall_cnt  out  CNT_W  cycles with pc_we=0.

Function
REQ-016 States: RUN, MEM_WAIT, ERR; encoding 2 bits.
REQ-017 A hazard SHALL never be raised for register 0.
REQ-018 Load-use (RUN): ex_memread & ex_regwrite & ex_rd matches id_rs/id_rt -> same cycle pc_we=0, ifid_we=0, idex_flush=1; the other enables stay 1.
REQ-019 Branch (RUN): mem_branch_taken=1 -> same cycle ifid_flush=idex_flush=exmem_flush=1, pc_we=1; branch overrides load-use.
REQ-020 RUN, dmem_req=1, dmem_ack=0 -> all *_we=0, memwb_flush=1 that cycle; next state MEM_WAIT.
REQ-021 MEM_WAIT: the freeze holds until a cycle with dmem_ack=1, which releases the freeze in that same cycle; next state RUN.
REQ-022 A branch or load-use hazard coincident with a memory wait SHALL be deferred until the cycle of dmem_ack, then handled per REQ-018/019.
REQ-023 Wait counter: cleared on entry to MEM_WAIT, +1 per MEM_WAIT cycle; after MEM_TIMEOUT MEM_WAIT cycles without ack -> ERR, mem_err=1.
REQ-024 ERR: pipeline frozen as in MEM_WAIT; exit only by reset.
REQ-025 Forwarding: fwd=10 if mem_regwrite & mem_rd matches the operand; else 01 if wb_regwrite & wb_rd matches; else 00; EX/MEM has priority.
REQ-026 stall_cnt +1 each cycle pc_we=0; saturates at all-ones, no wrap.
REQ-027 Outputs other than fwd_a/fwd_b are pure functions of state and inputs; no extra latency.

Reset
REQ-028 On rst: state RUN, wait counter 0, mem_err 0, stall_cnt 0, effective immediately (mid-stall included).
REQ-029 While rst=1: all *_we=1, all *_flush=0, fwd_a=fwd_b=00.

Configuration
REQ-030 Macro HAZARD_FORWARD_EN defined: forwarding per REQ-025.
REQ-031 Undefined: fwd_a=fwd_b=00 constant; an EX/MEM or MEM/WB producer matching id_rs/id_rt stalls as in REQ-018 until it retires.

Structure
REQ-032 Shared package hazard_pkg: state enum, fwd-select constants FWD_RF/FWD_WB/FWD_MEM.
REQ-033 One sub-module fwd_unit (combinational operand-select logic), instantiated twice (A, B).

Verification
REQ-034 lw $2 then add $3,$2,$4 -> exactly one cycle pc_we=0, idex_flush=1; stall_cnt=1.
REQ-035 add $2 then sub $5,$2,$2 -> fwd_a=fwd_b=10, no stall; undefined macro -> 2 stall cycles.
REQ-036 mem_branch_taken=1 -> ifid/idex/exmem_flush=1 one cycle, pc_we=1.
REQ-037 dmem_req=1, ack after 3 cycles -> 3 frozen cycles, release on ack cycle, state RUN.
REQ-038 dmem_req=1, never ack -> mem_err=1 after 15 cycles; rst mid-wait -> RUN, mem_err=0.
REQ-039 Writes to $0 in EX/MEM and MEM/WB -> fwd=00, no stall.
